// File: rtl/output_serializer.sv
// Streams a captured 3x3 result matrix as little-endian bytes over a valid/ready link.
// Each element contributes ceil(RES_W/8) bytes; padding bits above RES_W read as zero.
module output_serializer #(
  parameter int RES_W = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [9*RES_W-1:0] c_flat,
  output logic [7:0]         data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done
);
  localparam int NB = (RES_W + 7) / 8;
  localparam int PW = NB * 8;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           r_state;
  logic [RES_W-1:0] r_buf [0:8];
  logic [3:0]       r_e;
  logic [1:0]       r_b;

  logic       w_xfer;
  logic       w_last_b;
  logic       w_last;
  logic [3:0] w_nxt_e;
  logic [1:0] w_nxt_b;
  logic [7:0] w_nxt_byte;

  function automatic logic [7:0] byte_sel(input logic [RES_W-1:0] el, input logic [1:0] b);
    logic [PW-1:0] p;
    p = PW'(el) >> (8 * b);
    return p[7:0];
  endfunction

  // data_out is registered, so the byte after the pending transfer is looked up one step ahead
  always_comb begin
    w_xfer     = (r_state == SEND) && data_ready;
    w_last_b   = (r_b == 2'(NB - 1));
    w_last     = w_last_b && (r_e == 4'd8);
    w_nxt_e    = w_last_b ? r_e + 4'd1 : r_e;
    w_nxt_b    = w_last_b ? 2'd0 : r_b + 2'd1;
    w_nxt_byte = w_last ? 8'h00 : byte_sel(r_buf[w_last ? 4'd0 : w_nxt_e], w_nxt_b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_e        <= '0;
      r_b        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < 9; k++) r_buf[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < 9; k++) r_buf[k] <= c_flat[k*RES_W +: RES_W];
            r_e        <= '0;
            r_b        <= '0;
            data_out   <= c_flat[7:0];
            data_valid <= 1'b1;
            busy       <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_xfer) begin
            r_e      <= w_nxt_e;
            r_b      <= w_nxt_b;
            data_out <= w_nxt_byte;
            if (w_last) begin
              r_e        <= '0;
              r_b        <= '0;
              data_valid <= 1'b0;
              done       <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: frame content, latency, backpressure,
// ignored start, mid-frame reset and back-to-back frames.
module tb_output_serializer;
  localparam int RW = 18;

  logic            clk;
  logic            reset;
  logic            start;
  logic [9*RW-1:0] c_flat;
  logic [7:0]      data_out;
  logic            data_valid;
  logic            data_ready;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap[$];
  int         vcyc[$];
  int         done_cyc[$];
  logic       busy_log[$];
  int         stab_err;

  output_serializer #(.RES_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .c_flat(c_flat),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    start = 1'b0;
    data_ready = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Launches start and records what the DUT emits for ncyc cycles (no checking here).
  // mode 0: ready always high; mode 1: 1,0,0,1 ready pattern with random extra stalls.
  // hold: cycle at which start drops; inj >= 0 re-pulses start with new c_flat at that byte.
  task automatic observe(input int ncyc, input int mode, input int hold, input int inj);
    logic [7:0] prev_d;
    bit         prev_stall;
    bit         inj_done;
    cap.delete(); vcyc.delete(); done_cyc.delete(); busy_log.delete();
    stab_err = 0; prev_stall = 0; inj_done = 0; prev_d = '0;
    start = 1'b1;
    data_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      busy_log.push_back(busy);
      if (done) done_cyc.push_back(c);
      if (prev_stall && data_valid && data_out !== prev_d) stab_err++;
      if (inj >= 0 && !inj_done && data_valid && cap.size() == inj) begin
        start = 1'b1;
        for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'h3FFFF;
        inj_done = 1;
      end
      if (mode == 0) data_ready = 1'b1;
      else data_ready = ((c % 4 == 0) || (c % 4 == 3)) && ($urandom_range(0, 3) != 0);
      if (data_valid && data_ready) begin
        cap.push_back(data_out);
        vcyc.push_back(c);
      end
      prev_stall = data_valid && !data_ready;
      prev_d = data_out;
    end
    start = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic test_reset;
    start = 1'b0; data_ready = 1'b0; c_flat = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%h v=%b busy=%b done=%b required 00 0 0 0",
               data_out, data_valid, busy, done);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: v=%b busy=%b required 0 0", data_valid, busy);
    end
    start = 1'b0;
    reset = 1'b1;
    idle(2);
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: v=%b busy=%b done=%b required 0 0 0", data_valid, busy, done);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp;
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'(k + 1);
    observe(32, 0, 1, -1);
    checks++;
    if (cap.size() != 27) begin
      errors++; $display("FAIL basic_count: got %0d bytes required 27", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 27; i++) begin
      exp = (i % 3 == 0) ? 8'(i / 3 + 1) : 8'h00;
      checks++;
      if (cap[i] !== exp) begin
        errors++; $display("FAIL basic_byte[%0d]: got %h required %h", i, cap[i], exp);
      end
    end
    checks++;
    if (vcyc[0] !== 1 || vcyc[26] !== 27) begin
      errors++; $display("FAIL basic_timing: first %0d last %0d required 1 27", vcyc[0], vcyc[26]);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] !== 28) begin
      errors++; $display("FAIL basic_done: pulses %0d at %0d required 1 at 28", done_cyc.size(), done_cyc[0]);
    end
    checks++;
    if (busy_log[0] !== 1'b1 || busy_log[27] !== 1'b1 || busy_log[28] !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: c1=%b c28=%b c29=%b required 1 1 0", busy_log[0], busy_log[27], busy_log[28]);
    end
  endtask

  task automatic test_values;
    logic [7:0] exp;
    // even elements all-ones (top byte truncated to 03), odd elements 0x12345
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = (k % 2 == 0) ? 18'h3FFFF : 18'h12345;
    observe(32, 0, 1, -1);
    checks++;
    if (cap.size() != 27) begin
      errors++; $display("FAIL values_count: got %0d bytes required 27", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 27; i++) begin
      if ((i / 3) % 2 == 0) exp = (i % 3 == 2) ? 8'h03 : 8'hFF;
      else exp = (i % 3 == 0) ? 8'h45 : ((i % 3 == 1) ? 8'h23 : 8'h01);
      checks++;
      if (cap[i] !== exp) begin
        errors++; $display("FAIL values_byte[%0d]: got %h required %h", i, cap[i], exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp;
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'((k + 1) * 32'h1111);
    observe(400, 1, 1, -1);
    checks++;
    if (cap.size() != 27) begin
      errors++; $display("FAIL bp_count: got %0d bytes required 27", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 27; i++) begin
      exp = (i % 3 == 2) ? 8'h00 : 8'((i / 3 + 1) * 17);
      checks++;
      if (cap[i] !== exp) begin
        errors++; $display("FAIL bp_byte[%0d]: got %h required %h", i, cap[i], exp);
      end
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL bp_stable: %0d changes during stall required 0", stab_err);
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++; $display("FAIL bp_done: %0d pulses required 1", done_cyc.size());
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] exp;
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'h20000 | 18'(k << 8) | 18'(8'h50 + k);
    observe(45, 0, 1, 5);
    checks++;
    if (cap.size() != 27) begin
      errors++; $display("FAIL ign_count: got %0d bytes required 27", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 27; i++) begin
      case (i % 3)
        0:       exp = 8'(8'h50 + i / 3);
        1:       exp = 8'(i / 3);
        default: exp = 8'h02;
      endcase
      checks++;
      if (cap[i] !== exp) begin
        errors++; $display("FAIL ign_byte[%0d]: got %h required %h", i, cap[i], exp);
      end
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++; $display("FAIL ign_done: %0d pulses required 1", done_cyc.size());
    end
  endtask

  task automatic test_reset_midframe;
    int cnt;
    int stray;
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'h0ABCD;
    cnt = 0;
    start = 1'b1;
    data_ready = 1'b1;
    for (int c = 1; c <= 40 && cnt < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (data_valid) cnt++;
    end
    checks++;
    if (cnt != 10) begin
      errors++; $display("FAIL rst_mid_reach: %0d bytes required 10", cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: v=%b busy=%b done=%b required 0 0 0", data_valid, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (data_valid || done || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_mid_quiet: %0d active cycles required 0", stray);
    end
    data_ready = 1'b0;
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'(k + 1);
    observe(32, 0, 1, -1);
    checks++;
    if (cap.size() != 27 || cap[0] !== 8'h01 || cap[24] !== 8'h09 || cap[26] !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_fresh: n=%0d b0=%h b24=%h b26=%h required 27 01 09 00",
               cap.size(), cap[0], cap[24], cap[26]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    for (int k = 0; k < 9; k++) c_flat[k*RW +: RW] = 18'(k + 1);
    observe(57, 0, 1000, -1);
    checks++;
    if (cap.size() != 54) begin
      errors++; $display("FAIL b2b_count: got %0d bytes required 54", cap.size());
    end
    for (int i = 0; i < cap.size() && i < 54; i++) begin
      exp = ((i % 27) % 3 == 0) ? 8'((i % 27) / 3 + 1) : 8'h00;
      checks++;
      if (cap[i] !== exp) begin
        errors++; $display("FAIL b2b_byte[%0d]: got %h required %h", i, cap[i], exp);
      end
    end
    checks++;
    if (vcyc[26] !== 27 || vcyc[27] !== 30) begin
      errors++; $display("FAIL b2b_gap: last1 %0d first2 %0d required 27 30", vcyc[26], vcyc[27]);
    end
    checks++;
    if (busy_log[27] !== 1'b1 || busy_log[28] !== 1'b0 || busy_log[29] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: c28=%b c29=%b c30=%b required 1 0 1", busy_log[27], busy_log[28], busy_log[29]);
    end
    checks++;
    if (done_cyc.size() != 2 || done_cyc[0] !== 28 || done_cyc[1] !== 57) begin
      errors++;
      $display("FAIL b2b_done: pulses %0d at %0d,%0d required 2 at 28,57", done_cyc.size(), done_cyc[0], done_cyc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    idle(3);
    test_values();
    idle(3);
    test_backpressure();
    idle(3);
    test_start_ignored();
    idle(3);
    test_reset_midframe();
    idle(3);
    test_back_to_back();
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter: RES_W, default 18, width of one result element (legal 9..24); NB = ceil(RES_W/8) bytes per element (3 at default).
REQ-002 Port: clk  input  1  clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to capture and transmit a result matrix; sampled only in IDLE.
REQ-005 Port: c_flat  input  9*RES_W  packed 3x3 result matrix; element k (row-major, k=0..8) at bits [k*RES_W +: RES_W].
REQ-006 Port: data_out  output  8  current byte presented to the consumer.
REQ-007 Port: data_valid  output  1  data_out holds a valid byte.
REQ-008 Port: data_ready  input  1  consumer accepts the byte; transfer = data_valid && data_ready at a rising edge.
REQ-009 Port: busy  output  1  high in SEND and DONE states.
REQ-010 Port: done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-011 The block SHALL implement states IDLE, SEND, DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL copy c_flat into an internal 9-element buffer, clear element index e and byte index b, and enter SEND.
REQ-013 data_valid SHALL be 1 exactly while in SEND; first valid byte appears in the cycle after start is sampled (latency 1).
REQ-014 In SEND, data_out SHALL equal bits [b*8 +: 8] of buffer element e, with bits at or above RES_W forced to 0 (little-endian, LS byte first).
REQ-015 Byte order SHALL be e=0..8 outer, b=0..NB-1 inner, 9*NB bytes per frame (27 at default).
REQ-016 On a transfer, b SHALL increment; when b=NB-1, b wraps to 0 and e increments.
REQ-017 Without a transfer, data_out, e, b SHALL hold unchanged (data stable under backpressure).
REQ-018 A transfer with e=8, b=NB-1 SHALL move the block to DONE; data_valid deasserts in the next cycle.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-020 start asserted in SEND or DONE SHALL be ignored; c_flat changes after capture SHALL not affect the frame in progress.
REQ-021 start held continuously SHALL launch a new frame on the first IDLE cycle after DONE (one idle cycle between frames minimum).
REQ-022 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-023 On reset=0, state SHALL go to IDLE immediately, regardless of clk.
REQ-024 Reset values: data_out=0, data_valid=0, busy=0, done=0, e=0, b=0, buffer all zeros.
REQ-025 Reset mid-frame SHALL abandon the frame; no remaining bytes emitted after release, no done pulse.
REQ-026 After reset release, the first start SHALL begin a fresh frame at e=0, b=0.

Verification
REQ-027 c_flat element k = k+1, data_ready=1, pulse start -> bytes 01 00 00 02 00 00 ... 09 00 00 on 27 consecutive cycles, done one cycle after last transfer, busy low the cycle after.
REQ-028 All elements = 0x3FFFF -> each element emits FF FF 03; element = 0x12345 -> 45 23 01.
REQ-029 data_ready toggling 1,0,0,1 pattern with random stalls -> data_out stable during every stall, 27 bytes in order, none duplicated or skipped.
REQ-030 start pulsed at byte 5 of a frame with different c_flat -> ignored, original frame completes unchanged, no second frame.
REQ-031 reset=0 asserted after byte 10 transfers -> data_valid, busy, done low immediately; subsequent start emits full 27-byte frame from element 0.
REQ-032 start held high across two frames with ready=1 -> two complete 27-byte frames, exactly one non-valid DONE cycle and one IDLE cycle between them.
